// File: rtl/isp_param_writer_if.sv
// rtl/isp_param_writer_if.sv - header, vertex and VRAM write channels of the ISP parameter writer
// Purpose: bundles the handshake and bus signals between triangle setup,
//          the parameter writer and the VRAM write port.
// Signals:
//   header : base_addr, hdr_valid, hdr_ready, isp_inst, tsp_inst, tex_cont
//   vertex : vert_valid, vert_ready, vert_x/y/z/u/v, vert_base_col, vert_off_col
//   vram   : vram_wr, vram_addr, vram_dout, vram_wait
//   status : prim_done, next_addr
// Modports: slave = parameter writer, master = producer/consumer environment.
interface isp_param_writer_if;
   logic [23:0] base_addr;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [31:0] isp_inst;
   logic [31:0] tsp_inst;
   logic [31:0] tex_cont;
   logic        vert_valid;
   logic        vert_ready;
   logic [31:0] vert_x;
   logic [31:0] vert_y;
   logic [31:0] vert_z;
   logic [31:0] vert_u;
   logic [31:0] vert_v;
   logic [31:0] vert_base_col;
   logic [31:0] vert_off_col;
   logic        vram_wr;
   logic [23:0] vram_addr;
   logic [31:0] vram_dout;
   logic        vram_wait;
   logic        prim_done;
   logic [23:0] next_addr;

   modport slave (
      input  base_addr, hdr_valid, isp_inst, tsp_inst, tex_cont,
      input  vert_valid, vert_x, vert_y, vert_z, vert_u, vert_v, vert_base_col, vert_off_col,
      input  vram_wait,
      output hdr_ready, vert_ready, vram_wr, vram_addr, vram_dout, prim_done, next_addr
   );

   modport master (
      output base_addr, hdr_valid, isp_inst, tsp_inst, tex_cont,
      output vert_valid, vert_x, vert_y, vert_z, vert_u, vert_v, vert_base_col, vert_off_col,
      output vram_wait,
      input  hdr_ready, vert_ready, vram_wr, vram_addr, vram_dout, prim_done, next_addr
   );
endinterface

// File: rtl/isp_param_writer.sv
// rtl/isp_param_writer.sv - packs one polygon's ISP/TSP parameters into VRAM words
// Purpose: writes the header words (isp_inst, tsp_inst, tex_cont) followed by
//          VERTS_PER_PRIM vertices, each x, y, z, optional UV, base colour and
//          optional offset colour, at consecutive word addresses.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - synchronous active-low reset
//   bus     - isp_param_writer_if.slave: header/vertex handshakes, registered
//             VRAM write port with vram_wait stall, prim_done pulse, next_addr
module isp_param_writer #(
   parameter int VERTS_PER_PRIM = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   isp_param_writer_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_VWAIT, S_VERT, S_DONE} state_t;

   // Identifies the word currently presented on the VRAM port.
   typedef enum logic [3:0] {
      W_ISP, W_TSP, W_TEX, W_X, W_Y, W_Z, W_U, W_V, W_UV16, W_BASE, W_OFF, W_END
   } word_t;

   localparam logic [1:0] LAST_VERT = 2'(VERTS_PER_PRIM - 1);

   state_t      state_q, state_d;
   word_t       word_q, word_d;
   logic [1:0]  vcnt_q, vcnt_d;
   logic        texture_q, texture_d;
   logic        offset_q, offset_d;
   logic        uv16_q, uv16_d;
   logic [31:0] tsp_q, tsp_d;
   logic [31:0] tex_q, tex_d;
   logic [31:0] y_q, y_d;
   logic [31:0] z_q, z_d;
   logic [31:0] u_q, u_d;
   logic [31:0] v_q, v_d;
   logic [31:0] base_col_q, base_col_d;
   logic [31:0] off_col_q, off_col_d;
   logic        vram_wr_q, vram_wr_d;
   logic [23:0] vram_addr_q, vram_addr_d;
   logic [31:0] vram_dout_q, vram_dout_d;
   logic [23:0] next_addr_q, next_addr_d;

   logic        wr_done;
   word_t       vert_next;
   logic [31:0] vert_word;

   assign wr_done = vram_wr_q && !bus.vram_wait;

   assign bus.hdr_ready  = (state_q == S_IDLE);
   assign bus.vert_ready = (state_q == S_VWAIT);
   assign bus.prim_done  = (state_q == S_DONE);
   assign bus.vram_wr    = vram_wr_q;
   assign bus.vram_addr  = vram_addr_q;
   assign bus.vram_dout  = vram_dout_q;
   assign bus.next_addr  = next_addr_q;

   // Successor of the current vertex word; the optional fields are skipped
   // according to the flags latched with the header.
   always_comb begin
      vert_next = W_END;
      case (word_q)
         W_X:         vert_next = W_Y;
         W_Y:         vert_next = W_Z;
         W_Z:         vert_next = !texture_q ? W_BASE : (uv16_q ? W_UV16 : W_U);
         W_U:         vert_next = W_V;
         W_V, W_UV16: vert_next = W_BASE;
         W_BASE:      vert_next = offset_q ? W_OFF : W_END;
         default:     vert_next = W_END;
      endcase
   end

   always_comb begin
      vert_word = 32'd0;
      case (vert_next)
         W_Y:     vert_word = y_q;
         W_Z:     vert_word = z_q;
         W_U:     vert_word = u_q;
         W_V:     vert_word = v_q;
         W_UV16:  vert_word = {u_q[31:16], v_q[31:16]};
         W_BASE:  vert_word = base_col_q;
         W_OFF:   vert_word = off_col_q;
         default: vert_word = 32'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      vcnt_d      = vcnt_q;
      texture_d   = texture_q;
      offset_d    = offset_q;
      uv16_d      = uv16_q;
      tsp_d       = tsp_q;
      tex_d       = tex_q;
      y_d         = y_q;
      z_d         = z_q;
      u_d         = u_q;
      v_d         = v_q;
      base_col_d  = base_col_q;
      off_col_d   = off_col_q;
      vram_wr_d   = vram_wr_q;
      vram_addr_d = vram_addr_q;
      vram_dout_d = vram_dout_q;
      next_addr_d = next_addr_q;

      case (state_q)
         S_IDLE: begin
            if (bus.hdr_valid) begin
               texture_d   = bus.isp_inst[25];
               offset_d    = bus.isp_inst[24];
               uv16_d      = bus.isp_inst[22];
               tsp_d       = bus.tsp_inst;
               tex_d       = bus.tex_cont;
               // isp_inst goes straight to the port so it appears next cycle.
               vram_wr_d   = 1'b1;
               vram_addr_d = {bus.base_addr[23:2], 2'b00};
               vram_dout_d = bus.isp_inst;
               word_d      = W_ISP;
               vcnt_d      = 2'd0;
               state_d     = S_HDR;
            end
         end

         S_HDR: begin
            if (wr_done) begin
               case (word_q)
                  W_ISP: begin
                     word_d      = W_TSP;
                     vram_addr_d = vram_addr_q + 24'd4;
                     vram_dout_d = tsp_q;
                  end
                  W_TSP: begin
                     word_d      = W_TEX;
                     vram_addr_d = vram_addr_q + 24'd4;
                     vram_dout_d = tex_q;
                  end
                  default: begin
                     // Address stays on the last written word until the next
                     // vertex arrives; the increment happens at accept.
                     vram_wr_d = 1'b0;
                     state_d   = S_VWAIT;
                  end
               endcase
            end
         end

         S_VWAIT: begin
            if (bus.vert_valid) begin
               y_d         = bus.vert_y;
               z_d         = bus.vert_z;
               u_d         = bus.vert_u;
               v_d         = bus.vert_v;
               base_col_d  = bus.vert_base_col;
               off_col_d   = bus.vert_off_col;
               vram_wr_d   = 1'b1;
               vram_addr_d = vram_addr_q + 24'd4;
               vram_dout_d = bus.vert_x;
               word_d      = W_X;
               state_d     = S_VERT;
            end
         end

         S_VERT: begin
            if (wr_done) begin
               if (vert_next == W_END) begin
                  vram_wr_d = 1'b0;
                  if (vcnt_q == LAST_VERT) begin
                     next_addr_d = vram_addr_q + 24'd4;
                     state_d     = S_DONE;
                  end else begin
                     vcnt_d  = vcnt_q + 2'd1;
                     state_d = S_VWAIT;
                  end
               end else begin
                  word_d      = vert_next;
                  vram_addr_d = vram_addr_q + 24'd4;
                  vram_dout_d = vert_word;
               end
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         word_q      <= W_ISP;
         vcnt_q      <= 2'd0;
         texture_q   <= 1'b0;
         offset_q    <= 1'b0;
         uv16_q      <= 1'b0;
         tsp_q       <= 32'd0;
         tex_q       <= 32'd0;
         y_q         <= 32'd0;
         z_q         <= 32'd0;
         u_q         <= 32'd0;
         v_q         <= 32'd0;
         base_col_q  <= 32'd0;
         off_col_q   <= 32'd0;
         vram_wr_q   <= 1'b0;
         vram_addr_q <= 24'd0;
         vram_dout_q <= 32'd0;
         next_addr_q <= 24'd0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         vcnt_q      <= vcnt_d;
         texture_q   <= texture_d;
         offset_q    <= offset_d;
         uv16_q      <= uv16_d;
         tsp_q       <= tsp_d;
         tex_q       <= tex_d;
         y_q         <= y_d;
         z_q         <= z_d;
         u_q         <= u_d;
         v_q         <= v_d;
         base_col_q  <= base_col_d;
         off_col_q   <= off_col_d;
         vram_wr_q   <= vram_wr_d;
         vram_addr_q <= vram_addr_d;
         vram_dout_q <= vram_dout_d;
         next_addr_q <= next_addr_d;
      end
   end

endmodule

// File: tb/tb_isp_param_writer.sv
// tb/tb_isp_param_writer.sv - randomized self-checking bench for isp_param_writer
module tb_isp_param_writer;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        sel4 = 1'b0;
   logic [23:0] base_addr = '0;
   logic        hdr_valid = 1'b0;
   logic [31:0] isp_inst = '0, tsp_inst = '0, tex_cont = '0;
   logic        vert_valid = 1'b0;
   logic [31:0] vert_x = '0, vert_y = '0, vert_z = '0, vert_u = '0, vert_v = '0;
   logic [31:0] vert_base_col = '0, vert_off_col = '0;
   logic        vram_wait = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;

   isp_param_writer_if if3 ();
   isp_param_writer_if if4 ();

   assign if3.base_addr = base_addr;         assign if4.base_addr = base_addr;
   assign if3.hdr_valid = hdr_valid;         assign if4.hdr_valid = hdr_valid;
   assign if3.isp_inst = isp_inst;           assign if4.isp_inst = isp_inst;
   assign if3.tsp_inst = tsp_inst;           assign if4.tsp_inst = tsp_inst;
   assign if3.tex_cont = tex_cont;           assign if4.tex_cont = tex_cont;
   assign if3.vert_valid = vert_valid;       assign if4.vert_valid = vert_valid;
   assign if3.vert_x = vert_x;               assign if4.vert_x = vert_x;
   assign if3.vert_y = vert_y;               assign if4.vert_y = vert_y;
   assign if3.vert_z = vert_z;               assign if4.vert_z = vert_z;
   assign if3.vert_u = vert_u;               assign if4.vert_u = vert_u;
   assign if3.vert_v = vert_v;               assign if4.vert_v = vert_v;
   assign if3.vert_base_col = vert_base_col; assign if4.vert_base_col = vert_base_col;
   assign if3.vert_off_col = vert_off_col;   assign if4.vert_off_col = vert_off_col;
   assign if3.vram_wait = vram_wait;         assign if4.vram_wait = vram_wait;

   isp_param_writer #(.VERTS_PER_PRIM(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(if3));
   isp_param_writer #(.VERTS_PER_PRIM(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(if4));

   logic        o_hdr_ready, o_vert_ready, o_wr, o_done;
   logic [23:0] o_addr, o_next;
   logic [31:0] o_dout;
   assign o_hdr_ready  = sel4 ? if4.hdr_ready  : if3.hdr_ready;
   assign o_vert_ready = sel4 ? if4.vert_ready : if3.vert_ready;
   assign o_wr         = sel4 ? if4.vram_wr    : if3.vram_wr;
   assign o_done       = sel4 ? if4.prim_done  : if3.prim_done;
   assign o_addr       = sel4 ? if4.vram_addr  : if3.vram_addr;
   assign o_next       = sel4 ? if4.next_addr  : if3.next_addr;
   assign o_dout       = sel4 ? if4.vram_dout  : if3.vram_dout;

   task automatic junk_hdr();
      base_addr = 24'($urandom);
      isp_inst  = $urandom;
      tsp_inst  = $urandom;
      tex_cont  = $urandom;
   endtask

   task automatic junk_vert();
      vert_x = $urandom; vert_y = $urandom; vert_z = $urandom; vert_u = $urandom;
      vert_v = $urandom; vert_base_col = $urandom; vert_off_col = $urandom;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0; hdr_valid = 1'b0; vert_valid = 1'b0; vram_wait = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Drives one primitive and checks every completed write against a word list
   // built from the format rules.
   task automatic run_prim(input bit use4, input logic [23:0] base, input bit tex, input bit off,
                           input bit u16, input int vdelay, input int stall_pct, input bit stall_tsp,
                           input int abort_vert, input bit b2b, input bit fix_uv,
                           output int got_words, output logic [23:0] got_next, output logic [31:0] got_w6);
      int nv, nwords, cyc, t_acc, t_done, widx, vacc, wcnt, stalls, tsp_stalls;
      bit hdr_acc, finished, aborted, prev_stall;
      logic [23:0] a0, prev_addr;
      logic [31:0] isp, tsp, texc, prev_dout;
      logic [31:0] vxa [4], vya [4], vza [4], vua [4], vva [4], vba [4], voa [4];
      logic [31:0] exp_d [$];

      nv = use4 ? 4 : 3;
      sel4 = use4;
      isp = $urandom; isp[25] = tex; isp[24] = off; isp[22] = u16;
      tsp = $urandom; texc = $urandom;
      for (int v = 0; v < 4; v++) begin
         vxa[v] = $urandom; vya[v] = $urandom; vza[v] = $urandom; vua[v] = $urandom;
         vva[v] = $urandom; vba[v] = $urandom; voa[v] = $urandom;
      end
      if (fix_uv) begin vua[0] = 32'h3F80_1234; vva[0] = 32'h3F00_5678; end
      a0 = {base[23:2], 2'b00};
      exp_d = {};
      exp_d.push_back(isp); exp_d.push_back(tsp); exp_d.push_back(texc);
      for (int v = 0; v < nv; v++) begin
         exp_d.push_back(vxa[v]); exp_d.push_back(vya[v]); exp_d.push_back(vza[v]);
         if (tex && !u16) begin exp_d.push_back(vua[v]); exp_d.push_back(vva[v]); end
         if (tex && u16) exp_d.push_back({vua[v][31:16], vva[v][31:16]});
         exp_d.push_back(vba[v]);
         if (off) exp_d.push_back(voa[v]);
      end
      nwords = 3 + nv * (4 + (tex ? (u16 ? 1 : 2) : 0) + (off ? 1 : 0));

      got_words = 0; got_next = '0; got_w6 = '0;
      cyc = 0; t_acc = -1; t_done = -1; widx = 0; vacc = 0; wcnt = 0; stalls = 0; tsp_stalls = 0;
      hdr_acc = 0; finished = 0; aborted = 0; prev_stall = 0; prev_addr = '0; prev_dout = '0;

      while (!finished && cyc < 2000) begin
         @(negedge clock);
         cyc++;
         if (prev_stall) begin
            n_checks++;
            if (o_wr !== 1'b1 || o_addr !== prev_addr || o_dout !== prev_dout) begin
               n_fail++;
               $display("FAIL stall_hold: wr=%b addr=%h dout=%h, required wr=1 addr=%h dout=%h",
                        o_wr, o_addr, o_dout, prev_addr, prev_dout);
            end
         end
         hdr_valid = 1'b1;
         if (!hdr_acc) begin
            base_addr = base; isp_inst = isp; tsp_inst = tsp; tex_cont = texc;
         end else junk_hdr();
         if (hdr_acc && o_vert_ready && vacc < nv) begin
            if (wcnt >= vdelay) begin
               vert_valid = 1'b1;
               vert_x = vxa[vacc]; vert_y = vya[vacc]; vert_z = vza[vacc]; vert_u = vua[vacc];
               vert_v = vva[vacc]; vert_base_col = vba[vacc]; vert_off_col = voa[vacc];
            end else begin
               vert_valid = 1'b0; junk_vert(); wcnt++;
            end
         end else begin
            vert_valid = 1'($urandom_range(0, 1)); junk_vert();
         end
         if (stall_tsp && o_wr && o_addr == a0 + 24'd4 && tsp_stalls < 5) begin
            vram_wait = 1'b1; tsp_stalls++;
         end else vram_wait = ($urandom_range(0, 99) < stall_pct);

         if (abort_vert >= 0 && vacc == abort_vert + 1 && o_wr) begin
            reset_n = 1'b0; vram_wait = 1'b0; hdr_valid = 1'b0; vert_valid = 1'b0;
            aborted = 1; finished = 1;
         end else begin
            n_checks++;
            if ((o_hdr_ready && o_vert_ready) || (hdr_acc && o_hdr_ready)) begin
               n_fail++;
               $display("FAIL ready_decode: hdr_ready=%b vert_ready=%b busy=%b, required at most one and no hdr_ready while busy",
                        o_hdr_ready, o_vert_ready, hdr_acc);
            end
            if (hdr_valid && o_hdr_ready && !hdr_acc) begin hdr_acc = 1; t_acc = cyc; end
            if (vert_valid && o_vert_ready) begin vacc++; wcnt = 0; end
            if (o_vert_ready) begin
               n_checks++;
               if (o_wr !== 1'b0) begin
                  n_fail++; $display("FAIL vwait_wr: vram_wr=%b, required 0", o_wr);
               end
            end
            if (o_wr && !vram_wait) begin
               n_checks++;
               if (widx >= exp_d.size()) begin
                  n_fail++; $display("FAIL extra_write: addr=%h data=%h beyond %0d words", o_addr, o_dout, exp_d.size());
               end else if (o_addr !== a0 + 24'(4 * widx) || o_dout !== exp_d[widx]) begin
                  n_fail++;
                  $display("FAIL word%0d: addr=%h data=%h, required addr=%h data=%h",
                           widx, o_addr, o_dout, a0 + 24'(4 * widx), exp_d[widx]);
               end
               if (widx == 6) got_w6 = o_dout;
               widx++;
            end
            if (o_wr && vram_wait) stalls++;
            prev_stall = o_wr && vram_wait; prev_addr = o_addr; prev_dout = o_dout;
            if (o_done) begin
               t_done = cyc; got_next = o_next; finished = 1;
            end
         end
      end
      got_words = widx;

      if (aborted) begin
         @(negedge clock);
         reset_n = 1'b1; hdr_valid = 1'b0; vert_valid = 1'b0; vram_wait = 1'b0;
         n_checks++;
         if (o_wr !== 1'b0 || o_done !== 1'b0 || o_hdr_ready !== 1'b1 || o_vert_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: wr=%b done=%b hdr_ready=%b vert_ready=%b, required 0 0 1 0",
                     o_wr, o_done, o_hdr_ready, o_vert_ready);
         end
         for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (o_wr !== 1'b0 || o_done !== 1'b0) begin
               n_fail++; $display("FAIL abort_quiet: wr=%b done=%b, required 0 0", o_wr, o_done);
            end
         end
         return;
      end

      n_checks++;
      if (!finished) begin n_fail++; $display("FAIL timeout: no prim_done within %0d cycles", cyc); end
      n_checks++;
      if (widx != nwords) begin n_fail++; $display("FAIL word_count: %0d, required %0d", widx, nwords); end
      n_checks++;
      if (got_next !== a0 + 24'(4 * nwords)) begin
         n_fail++; $display("FAIL next_addr: %h, required %h", got_next, a0 + 24'(4 * nwords));
      end
      n_checks++;
      if (t_acc != 1) begin n_fail++; $display("FAIL hdr_accept: cycle %0d, required 1", t_acc); end
      n_checks++;
      if (t_done - t_acc != nwords + nv * (1 + vdelay) + 1 + stalls) begin
         n_fail++;
         $display("FAIL latency: %0d cycles, required %0d", t_done - t_acc, nwords + nv * (1 + vdelay) + 1 + stalls);
      end
      if (stall_tsp) begin
         n_checks++;
         if (tsp_stalls != 5) begin n_fail++; $display("FAIL tsp_stall: %0d stalled cycles applied, required 5", tsp_stalls); end
      end
      if (!b2b) begin
         @(negedge clock);
         hdr_valid = 1'b0; vert_valid = 1'b0; vram_wait = 1'b0;
         n_checks++;
         if (o_hdr_ready !== 1'b1 || o_done !== 1'b0 || o_wr !== 1'b0 || o_next !== got_next) begin
            n_fail++;
            $display("FAIL post_done: hdr_ready=%b done=%b wr=%b next=%h, required 1 0 0 %h",
                     o_hdr_ready, o_done, o_wr, o_next, got_next);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset_n = 1'b0; hdr_valid = 1'b1; base_addr = 24'h123456; vert_valid = 1'b1; vram_wait = 1'b0;
      @(negedge clock);
      sel4 = 1'b0; #1;
      n_checks++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: %b, required 0", o_wr); end
      n_checks++; if (o_addr !== 24'h0) begin n_fail++; $display("FAIL rst_addr: %h, required 000000", o_addr); end
      n_checks++; if (o_dout !== 32'h0) begin n_fail++; $display("FAIL rst_dout: %h, required 0", o_dout); end
      n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: %b, required 0", o_done); end
      n_checks++; if (o_next !== 24'h0) begin n_fail++; $display("FAIL rst_next: %h, required 000000", o_next); end
      n_checks++; if (o_vert_ready !== 1'b0) begin n_fail++; $display("FAIL rst_vert_ready: %b, required 0", o_vert_ready); end
      n_checks++; if (o_hdr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hdr_ready: %b, required 1", o_hdr_ready); end
      sel4 = 1'b1; #1;
      n_checks++;
      if (o_wr !== 1'b0 || o_addr !== 24'h0 || o_done !== 1'b0 || o_hdr_ready !== 1'b1 || o_vert_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_dut4: wr=%b addr=%h done=%b hdr_ready=%b vert_ready=%b", o_wr, o_addr, o_done, o_hdr_ready, o_vert_ready);
      end
      sel4 = 1'b0;
      @(negedge clock);
      reset_n = 1'b1; hdr_valid = 1'b0; vert_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: wr=%b, required 0", o_wr); end
   endtask

   task automatic test_untextured();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'h00408C, 0, 0, 0, 0, 0, 0, -1, 0, 0, w, nx, w6);
      n_checks++; if (w != 15) begin n_fail++; $display("FAIL untex_words: %0d, required 15", w); end
      n_checks++; if (nx !== 24'h0040C8) begin n_fail++; $display("FAIL untex_next: %h, required 0040C8", nx); end
   endtask

   task automatic test_textured_offset();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'($urandom), 1, 1, 0, 0, 0, 0, -1, 0, 0, w, nx, w6);
      n_checks++; if (w != 24) begin n_fail++; $display("FAIL tex_off_words: %0d, required 24", w); end
   endtask

   task automatic test_uv16();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'($urandom), 1, 0, 1, 0, 0, 0, -1, 0, 1, w, nx, w6);
      n_checks++; if (w != 18) begin n_fail++; $display("FAIL uv16_words: %0d, required 18", w); end
      n_checks++; if (w6 !== 32'h3F803F00) begin n_fail++; $display("FAIL uv16_word: %h, required 3F803F00", w6); end
   endtask

   task automatic test_stall();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'($urandom), 0, 1, 0, 0, 0, 1, -1, 0, 0, w, nx, w6);
   endtask

   task automatic test_wrap();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'hFFFFF8, 0, 0, 0, 0, 0, 0, -1, 0, 0, w, nx, w6);
      n_checks++; if (nx !== 24'h000034) begin n_fail++; $display("FAIL wrap_next: %h, required 000034", nx); end
   endtask

   task automatic test_back_to_back();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'($urandom), 1, 0, 0, 0, 20, 0, -1, 1, 0, w, nx, w6);
      run_prim(0, 24'($urandom), 1, 1, 1, 0, 20, 0, -1, 0, 0, w, nx, w6);
   endtask

   task automatic test_reset_mid();
      int w; logic [23:0] nx; logic [31:0] w6;
      run_prim(0, 24'($urandom), 1, 1, 0, 0, 0, 0, 1, 0, 0, w, nx, w6);
      run_prim(0, 24'($urandom), 0, 1, 0, 0, 0, 0, -1, 0, 0, w, nx, w6);
   endtask

   task automatic test_v4_delay();
      int w; logic [23:0] nx; logic [31:0] w6;
      do_reset();
      run_prim(1, 24'($urandom), 0, 0, 0, 3, 0, 0, -1, 0, 0, w, nx, w6);
      n_checks++; if (w != 19) begin n_fail++; $display("FAIL v4_words: %0d, required 19", w); end
   endtask

   task automatic test_random();
      int w; logic [23:0] nx; logic [31:0] w6;
      for (int i = 0; i < 8; i++) begin
         do_reset();
         run_prim(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2), 25, 0, -1, 0, 0, w, nx, w6);
      end
   endtask

   initial begin
      test_reset();
      test_untextured();
      test_textured_offset();
      test_uv16();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_v4_delay();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
